spi_register_sequencer: RTL and testbench
=========================================

Name: spi_register_sequencer

Overview:
- Command-level front end that sits directly upstream of the half-duplex SPI transaction engine, in the fabric_clk domain.
- Accepts register read/write commands into a small queue. Each command becomes one SPI frame: length, data and rw_mask words, presented with a single-cycle nonzero length.
- Matches returned read data to the outstanding read and reports completion or timeout.
- Enforces a minimum inter-frame gap, because the downstream engine exposes no busy/done signal.

Parameters:
DATA_WIDTH, 32, width of transaction_data/rw_mask/read_data words
TRANSACTION_LEN_WIDTH, 6, width of transaction_length
ADDR_WIDTH, 15, register address bits per frame
REG_DATA_WIDTH, 8, register data bits per frame
CMD_DEPTH, 4, command queue entries (power of 2, >=2)
GAP_CYCLES, 64, idle fabric_clk cycles enforced after each frame completes (0 allowed)
TIMEOUT_CYCLES, 4096, max cycles waiting for read data (>=1)

Ports:
fabric_clk  in  1  sole clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  queue not full
cmd_read  in  1  1=read, 0=write
cmd_addr  in  ADDR_WIDTH  register address
cmd_wdata  in  REG_DATA_WIDTH  write data (ignored for reads)
rsp_valid  out  1  one-cycle completion pulse
rsp_read  out  1  completed command was a read
rsp_rdata  out  REG_DATA_WIDTH  read data (0 for writes/timeouts)
rsp_timeout  out  1  read timed out (qualified by rsp_valid)
transaction_length  out  TRANSACTION_LEN_WIDTH  frame length; nonzero for exactly one cycle per frame
transaction_data  out  DATA_WIDTH  frame bits
transaction_rw_mask  out  DATA_WIDTH  1=drive bit, 0=sample bit
spi_read_valid  in  1  read word available from engine
spi_read_data  in  DATA_WIDTH  read word from engine
busy  out  1  state != IDLE or queue nonempty
timeout_count  out  8  saturating count of read timeouts

Behaviour:
- Fixed: one clock (fabric_clk); reset_n asynchronous, active-low.
- Reset: all outputs 0 except cmd_ready=1. Queue emptied; FSM to IDLE; counters cleared. Reset mid-frame aborts without rsp_valid.
- Frame length L = 1+ADDR_WIDTH+REG_DATA_WIDTH (default 24). Elaboration error if L > DATA_WIDTH or L >= 2^TRANSACTION_LEN_WIDTH.
- transaction_data layout:
  - bit L-1 = cmd_read
  - [L-2:REG_DATA_WIDTH] = addr
  - [REG_DATA_WIDTH-1:0] = wdata for writes, 0 for reads
  - bits >= L are 0
- transaction_rw_mask: writes = L ones; reads = ones on [L-1:REG_DATA_WIDTH], zeros below; bits >= L are 0.
- Queue: push on cmd_valid&cmd_ready. cmd_ready = !full, registered from occupancy. No push when full. Push and pop in the same cycle are both honoured.
- FSM states: IDLE, ISSUE, WAIT_READ, RESP, GAP.
  - IDLE: queue nonempty -> pop head, register frame words, go to ISSUE.
  - ISSUE (1 cycle): transaction_length=L. Write -> GAP, with rsp_valid (rsp_read=0, rdata=0) in the first GAP cycle. Read -> WAIT_READ; timeout counter cleared.
  - WAIT_READ: spi_read_valid -> latch spi_read_data[REG_DATA_WIDTH-1:0], go to RESP. Counter reaching TIMEOUT_CYCLES with no valid -> RESP with timeout flag; timeout_count++ (saturates at 255). Valid and expiry in the same cycle: valid wins.
  - RESP (1 cycle): rsp_valid=1, rsp_read=1, rsp_rdata/rsp_timeout per outcome -> GAP.
  - GAP: count GAP_CYCLES cycles, then IDLE. GAP_CYCLES=0 -> IDLE next cycle.
- spi_read_valid outside WAIT_READ is ignored and dropped.
- transaction_length is 0 in every state except ISSUE. transaction_data/rw_mask hold their last values.
- Latency, empty queue: cmd accepted at edge N -> ISSUE cycle N+2. Write rsp_valid at N+3.
- Minimum ISSUE-to-ISSUE spacing for back-to-back writes: GAP_CYCLES+2 cycles.
- No rsp backpressure: a consumer must accept every rsp_valid pulse.

Test Plan:
- Write addr=0x0012 data=0xA5 (defaults) -> one cycle with transaction_length=24, transaction_data=0x0012A5, rw_mask=0xFFFFFF; rsp_valid next cycle, rsp_read=0.
- Read addr=0x7FFF -> data=0xFFFF00, rw_mask=0xFFFF00, length=24. Drive spi_read_valid with spi_read_data=0x3C after 40 cycles -> rsp_valid, rsp_rdata=0x3C, rsp_timeout=0.
- Read with spi_read_valid never asserted, TIMEOUT_CYCLES=16 -> rsp_valid exactly 16 cycles after WAIT_READ entry; rsp_timeout=1; rdata=0; timeout_count=1. A stray valid afterwards is ignored.
- Push 6 writes back-to-back with GAP_CYCLES=4 -> cmd_ready drops after 4 entries are queued. All 6 frames issue in order; nonzero lengths spaced exactly 6 cycles apart; 6 rsp pulses.
- Assert reset_n low mid-WAIT_READ with 2 commands queued -> outputs return to reset values immediately; no rsp_valid; after release busy=0 and no frame is issued.
- spi_read_valid coinciding with the timeout expiry cycle -> data response, rsp_timeout=0, timeout_count unchanged.

Source files
------------

// File: rtl/spi_register_sequencer.sv
// Register read/write command queue feeding a half-duplex SPI transaction engine.
// Each command becomes one frame; read data is matched back, with timeout and a fixed inter-frame gap.
module spi_register_sequencer #(
  parameter int unsigned DATA_WIDTH            = 32,
  parameter int unsigned TRANSACTION_LEN_WIDTH = 6,
  parameter int unsigned ADDR_WIDTH            = 15,
  parameter int unsigned REG_DATA_WIDTH        = 8,
  parameter int unsigned CMD_DEPTH             = 4,
  parameter int unsigned GAP_CYCLES            = 64,
  parameter int unsigned TIMEOUT_CYCLES        = 4096
) (
  input  logic                             fabric_clk,
  input  logic                             reset_n,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_read,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [REG_DATA_WIDTH-1:0]        cmd_wdata,
  output logic                             rsp_valid,
  output logic                             rsp_read,
  output logic [REG_DATA_WIDTH-1:0]        rsp_rdata,
  output logic                             rsp_timeout,
  output logic [TRANSACTION_LEN_WIDTH-1:0] transaction_length,
  output logic [DATA_WIDTH-1:0]            transaction_data,
  output logic [DATA_WIDTH-1:0]            transaction_rw_mask,
  input  logic                             spi_read_valid,
  input  logic [DATA_WIDTH-1:0]            spi_read_data,
  output logic                             busy,
  output logic [7:0]                       timeout_count
);

  localparam int unsigned L         = 1 + ADDR_WIDTH + REG_DATA_WIDTH;
  localparam int unsigned PW        = $clog2(CMD_DEPTH);
  localparam int unsigned CW        = PW + 1;
  localparam int unsigned TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GW        = $clog2(GAP_CYCLES + 2);
  localparam int unsigned GAP_LAST  = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_READ = 3'd2;
  localparam logic [2:0] S_RESP      = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;

  if (L > DATA_WIDTH || L >= (1 << TRANSACTION_LEN_WIDTH)) begin : g_bad_frame_len
    $error("spi_register_sequencer: frame length does not fit DATA_WIDTH/TRANSACTION_LEN_WIDTH");
  end
  if (CMD_DEPTH < 2 || (1 << PW) != CMD_DEPTH) begin : g_bad_depth
    $error("spi_register_sequencer: CMD_DEPTH must be a power of 2 and >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("spi_register_sequencer: TIMEOUT_CYCLES must be >= 1");
  end

  logic [L-1:0]               r_mem [CMD_DEPTH];
  logic [PW-1:0]              r_wr_ptr;
  logic [PW-1:0]              r_rd_ptr;
  logic [CW-1:0]              r_count;
  logic                       r_cmd_ready;
  logic [2:0]                 r_state;
  logic                       r_is_read;
  logic [TW-1:0]              r_to_cnt;
  logic [GW-1:0]              r_gap_cnt;
  logic [TRANSACTION_LEN_WIDTH-1:0] r_tx_len;
  logic [DATA_WIDTH-1:0]      r_tx_data;
  logic [DATA_WIDTH-1:0]      r_tx_mask;
  logic                       r_rsp_valid;
  logic                       r_rsp_read;
  logic [REG_DATA_WIDTH-1:0]  r_rsp_rdata;
  logic                       r_rsp_timeout;
  logic [7:0]                 r_timeout_count;

  logic                       w_push;
  logic                       w_pop;
  logic [CW-1:0]              w_count_next;
  logic [L-1:0]               w_head;
  logic                       w_head_read;
  logic [ADDR_WIDTH-1:0]      w_head_addr;
  logic [DATA_WIDTH-1:0]      w_frame_data;
  logic [DATA_WIDTH-1:0]      w_frame_mask;
  logic                       w_unused;

  assign w_push      = cmd_valid & r_cmd_ready;
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_read = w_head[L-1];
  assign w_head_addr = w_head[L-2:REG_DATA_WIDTH];
  assign w_unused    = ^spi_read_data[DATA_WIDTH-1:REG_DATA_WIDTH];

  always_comb begin
    unique case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Reads drive rw/addr and sample the data field; writes drive the whole frame.
  always_comb begin
    w_frame_data = '0;
    w_frame_mask = '0;
    if (w_head_read) begin
      w_frame_data[L-1:0] = {1'b1, w_head_addr, {REG_DATA_WIDTH{1'b0}}};
      w_frame_mask[L-1:0] = {{(L-REG_DATA_WIDTH){1'b1}}, {REG_DATA_WIDTH{1'b0}}};
    end else begin
      w_frame_data[L-1:0] = w_head;
      w_frame_mask[L-1:0] = '1;
    end
  end

  always_ff @(posedge fabric_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {cmd_read, cmd_addr, cmd_wdata};
  end

  always_ff @(posedge fabric_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_cmd_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count     <= w_count_next;
      r_cmd_ready <= (w_count_next != CW'(CMD_DEPTH));
    end
  end

  always_ff @(posedge fabric_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_is_read       <= 1'b0;
      r_to_cnt        <= '0;
      r_gap_cnt       <= '0;
      r_tx_len        <= '0;
      r_tx_data       <= '0;
      r_tx_mask       <= '0;
      r_rsp_valid     <= 1'b0;
      r_rsp_read      <= 1'b0;
      r_rsp_rdata     <= '0;
      r_rsp_timeout   <= 1'b0;
      r_timeout_count <= '0;
    end else begin
      r_tx_len      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_read    <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_timeout <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (r_count != '0) begin
            r_tx_data <= w_frame_data;
            r_tx_mask <= w_frame_mask;
            r_is_read <= w_head_read;
            r_tx_len  <= TRANSACTION_LEN_WIDTH'(L);
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_is_read) begin
            r_to_cnt <= '0;
            r_state  <= S_WAIT_READ;
          end else begin
            r_gap_cnt   <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_GAP;
          end
        end
        S_WAIT_READ: begin
          // Response outputs are loaded on entry so they are visible during RESP.
          if (spi_read_valid) begin
            r_rsp_valid <= 1'b1;
            r_rsp_read  <= 1'b1;
            r_rsp_rdata <= spi_read_data[REG_DATA_WIDTH-1:0];
            r_state     <= S_RESP;
          end else if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_read    <= 1'b1;
            r_rsp_timeout <= 1'b1;
            if (r_timeout_count != 8'hFF) r_timeout_count <= r_timeout_count + 8'd1;
            r_state       <= S_RESP;
          end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
          end
        end
        S_RESP: begin
          r_gap_cnt <= '0;
          r_state   <= S_GAP;
        end
        S_GAP: begin
          if (r_gap_cnt == GW'(GAP_LAST)) r_state <= S_IDLE;
          else                            r_gap_cnt <= r_gap_cnt + GW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready           = r_cmd_ready;
  assign rsp_valid           = r_rsp_valid;
  assign rsp_read            = r_rsp_read;
  assign rsp_rdata           = r_rsp_rdata;
  assign rsp_timeout         = r_rsp_timeout;
  assign transaction_length  = r_tx_len;
  assign transaction_data    = r_tx_data;
  assign transaction_rw_mask = r_tx_mask;
  assign busy                = (r_state != S_IDLE) || (r_count != '0);
  assign timeout_count       = r_timeout_count;

endmodule

// File: tb/tb_spi_register_sequencer.sv
// Directed bench for spi_register_sequencer: instance A (GAP 4, TIMEOUT 16) and instance B (defaults).
module tb_spi_register_sequencer;

  logic        clk;
  logic        a_rst_n, b_rst_n;
  int          checks = 0;
  int          errors = 0;

  logic        a_cmd_valid, a_cmd_ready, a_cmd_read, a_rsp_valid, a_rsp_read, a_rsp_timeout;
  logic [14:0] a_cmd_addr;
  logic [7:0]  a_cmd_wdata, a_rsp_rdata, a_tocnt;
  logic [5:0]  a_tlen;
  logic [31:0] a_tdata, a_tmask, a_spi_rd;
  logic        a_spi_rv, a_busy;

  logic        b_cmd_valid, b_cmd_ready, b_cmd_read, b_rsp_valid, b_rsp_read, b_rsp_timeout;
  logic [14:0] b_cmd_addr;
  logic [7:0]  b_cmd_wdata, b_rsp_rdata, b_tocnt;
  logic [5:0]  b_tlen;
  logic [31:0] b_tdata, b_tmask, b_spi_rd;
  logic        b_spi_rv, b_busy;

  spi_register_sequencer #(.GAP_CYCLES(4), .TIMEOUT_CYCLES(16)) u_dut_a (
    .fabric_clk(clk), .reset_n(a_rst_n),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_read(a_cmd_read),
    .cmd_addr(a_cmd_addr), .cmd_wdata(a_cmd_wdata),
    .rsp_valid(a_rsp_valid), .rsp_read(a_rsp_read), .rsp_rdata(a_rsp_rdata),
    .rsp_timeout(a_rsp_timeout), .transaction_length(a_tlen),
    .transaction_data(a_tdata), .transaction_rw_mask(a_tmask),
    .spi_read_valid(a_spi_rv), .spi_read_data(a_spi_rd),
    .busy(a_busy), .timeout_count(a_tocnt)
  );

  spi_register_sequencer u_dut_b (
    .fabric_clk(clk), .reset_n(b_rst_n),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_read(b_cmd_read),
    .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata),
    .rsp_valid(b_rsp_valid), .rsp_read(b_rsp_read), .rsp_rdata(b_rsp_rdata),
    .rsp_timeout(b_rsp_timeout), .transaction_length(b_tlen),
    .transaction_data(b_tdata), .transaction_rw_mask(b_tmask),
    .spi_read_valid(b_spi_rv), .spi_read_data(b_spi_rd),
    .busy(b_busy), .timeout_count(b_tocnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic push_a(input logic rd, input logic [14:0] addr, input logic [7:0] wd);
    a_cmd_valid = 1'b1; a_cmd_read = rd; a_cmd_addr = addr; a_cmd_wdata = wd;
    @(posedge clk); #1;
    a_cmd_valid = 1'b0;
  endtask

  task automatic push_b(input logic rd, input logic [14:0] addr, input logic [7:0] wd);
    b_cmd_valid = 1'b1; b_cmd_read = rd; b_cmd_addr = addr; b_cmd_wdata = wd;
    @(posedge clk); #1;
    b_cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if ({a_cmd_ready, a_busy, a_rsp_valid, a_rsp_read, a_rsp_timeout} !== 5'b10000) begin
      errors++; $display("FAIL rst_a_flags got %b required 10000", {a_cmd_ready, a_busy, a_rsp_valid, a_rsp_read, a_rsp_timeout}); end
    checks++; if ({a_tlen, a_tdata, a_tmask, a_rsp_rdata, a_tocnt} !== '0) begin
      errors++; $display("FAIL rst_a_words got len=%h data=%h mask=%h rdata=%h tocnt=%h required 0", a_tlen, a_tdata, a_tmask, a_rsp_rdata, a_tocnt); end
    checks++; if ({b_cmd_ready, b_busy, b_rsp_valid, b_rsp_read, b_rsp_timeout} !== 5'b10000) begin
      errors++; $display("FAIL rst_b_flags got %b required 10000", {b_cmd_ready, b_busy, b_rsp_valid, b_rsp_read, b_rsp_timeout}); end
    checks++; if ({b_tlen, b_tdata, b_tmask, b_rsp_rdata, b_tocnt} !== '0) begin
      errors++; $display("FAIL rst_b_words got len=%h data=%h mask=%h rdata=%h tocnt=%h required 0", b_tlen, b_tdata, b_tmask, b_rsp_rdata, b_tocnt); end
  endtask

  task automatic test_write;
    push_b(1'b0, 15'h0012, 8'hA5);
    checks++; if (b_tlen !== 6'd0) begin errors++; $display("FAIL wr_len_early got %0d required 0", b_tlen); end
    @(posedge clk); #1;
    checks++; if (b_tlen !== 6'd24) begin errors++; $display("FAIL wr_len got %0d required 24", b_tlen); end
    checks++; if (b_tdata !== 32'h0012A5) begin errors++; $display("FAIL wr_data got %h required 000012a5", b_tdata); end
    checks++; if (b_tmask !== 32'h00FFFFFF) begin errors++; $display("FAIL wr_mask got %h required 00ffffff", b_tmask); end
    checks++; if (b_rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rsp_early got %b required 0", b_rsp_valid); end
    @(posedge clk); #1;
    checks++; if ({b_rsp_valid, b_rsp_read, b_rsp_timeout} !== 3'b100) begin
      errors++; $display("FAIL wr_rsp got %b required 100", {b_rsp_valid, b_rsp_read, b_rsp_timeout}); end
    checks++; if ({b_rsp_rdata, b_tlen} !== '0) begin
      errors++; $display("FAIL wr_rsp_rdata_len got rdata=%h len=%0d required 0", b_rsp_rdata, b_tlen); end
    checks++; if (b_tdata !== 32'h0012A5) begin errors++; $display("FAIL wr_data_hold got %h required 000012a5", b_tdata); end
    @(posedge clk); #1;
    checks++; if (b_rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rsp_pulse got %b required 0", b_rsp_valid); end
    for (int k = 0; k < 100 && b_busy; k++) begin @(posedge clk); #1; end
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL wr_idle got busy=%b required 0", b_busy); end
  endtask

  task automatic test_read_data;
    int n_rsp;
    push_b(1'b1, 15'h7FFF, 8'h77);
    @(posedge clk); #1;
    checks++; if (b_tlen !== 6'd24) begin errors++; $display("FAIL rd_len got %0d required 24", b_tlen); end
    checks++; if (b_tdata !== 32'h00FFFF00) begin errors++; $display("FAIL rd_data got %h required 00ffff00", b_tdata); end
    checks++; if (b_tmask !== 32'h00FFFF00) begin errors++; $display("FAIL rd_mask got %h required 00ffff00", b_tmask); end
    n_rsp = 0;
    repeat (40) begin @(posedge clk); #1; if (b_rsp_valid) n_rsp++; end
    checks++; if (n_rsp !== 0 || b_busy !== 1'b1) begin
      errors++; $display("FAIL rd_wait got rsp=%0d busy=%b required 0 1", n_rsp, b_busy); end
    b_spi_rv = 1'b1; b_spi_rd = 32'hAA00003C;
    @(posedge clk); #1;
    b_spi_rv = 1'b0; b_spi_rd = '0;
    checks++; if ({b_rsp_valid, b_rsp_read, b_rsp_timeout} !== 3'b110) begin
      errors++; $display("FAIL rd_rsp got %b required 110", {b_rsp_valid, b_rsp_read, b_rsp_timeout}); end
    checks++; if (b_rsp_rdata !== 8'h3C) begin errors++; $display("FAIL rd_rdata got %h required 3c", b_rsp_rdata); end
    checks++; if (b_tocnt !== 8'd0) begin errors++; $display("FAIL rd_tocnt got %0d required 0", b_tocnt); end
    for (int k = 0; k < 100 && b_busy; k++) begin @(posedge clk); #1; end
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL rd_idle got busy=%b required 0", b_busy); end
  endtask

  task automatic test_timeout;
    int found, n_bad;
    logic [2:0] flags;
    logic [7:0] rdata, tocnt;
    found = 0; flags = '0; rdata = '0; tocnt = '0;
    push_a(1'b1, 15'h0155, 8'h00);
    @(posedge clk); #1;
    for (int k = 1; k <= 40 && found == 0; k++) begin
      @(posedge clk); #1;
      if (a_rsp_valid) begin
        found = k; flags = {a_rsp_valid, a_rsp_read, a_rsp_timeout}; rdata = a_rsp_rdata; tocnt = a_tocnt;
      end
    end
    checks++; if (found !== 17) begin errors++; $display("FAIL to_latency got %0d required 17", found); end
    checks++; if (flags !== 3'b111) begin errors++; $display("FAIL to_flags got %b required 111", flags); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL to_rdata got %h required 00", rdata); end
    checks++; if (tocnt !== 8'd1) begin errors++; $display("FAIL to_count got %0d required 1", tocnt); end
    for (int k = 0; k < 20 && a_busy; k++) begin @(posedge clk); #1; end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL to_idle got busy=%b required 0", a_busy); end
    a_spi_rv = 1'b1; a_spi_rd = 32'h00000099;
    @(posedge clk); #1;
    a_spi_rv = 1'b0; a_spi_rd = '0;
    n_bad = 0;
    repeat (10) begin @(posedge clk); #1; if (a_rsp_valid || a_tlen != 0 || a_busy) n_bad++; end
    checks++; if (n_bad !== 0 || a_tocnt !== 8'd1) begin
      errors++; $display("FAIL to_stray got bad=%0d tocnt=%0d required 0 1", n_bad, a_tocnt); end
  endtask

  task automatic test_back_to_back;
    int acc, acc_at_drop, n_issue, n_rsp;
    int issue_cyc [6];
    logic [31:0] issue_data [6];
    logic [31:0] exp_data;
    logic ready_prev;
    acc = 0; acc_at_drop = -1; n_issue = 0; n_rsp = 0;
    a_cmd_valid = 1'b1; a_cmd_read = 1'b0; a_cmd_addr = 15'h100; a_cmd_wdata = 8'h01;
    ready_prev = a_cmd_ready;
    for (int cyc = 1; cyc <= 150 && !(n_rsp >= 6 && !a_busy); cyc++) begin
      @(posedge clk); #1;
      if (a_cmd_valid && ready_prev) acc++;
      if (a_tlen != 0) begin
        if (n_issue < 6) begin issue_cyc[n_issue] = cyc; issue_data[n_issue] = a_tdata; end
        n_issue++;
      end
      if (a_rsp_valid) n_rsp++;
      if (!a_cmd_ready && acc_at_drop < 0) acc_at_drop = acc;
      if (acc < 6) begin
        a_cmd_valid = 1'b1; a_cmd_addr = 15'(32'h100 + acc); a_cmd_wdata = 8'(acc * 16 + 1);
      end else a_cmd_valid = 1'b0;
      ready_prev = a_cmd_ready;
    end
    checks++; if (acc !== 6) begin errors++; $display("FAIL b2b_accepted got %0d required 6", acc); end
    checks++; if (acc_at_drop !== 5) begin errors++; $display("FAIL b2b_ready_drop got accepted=%0d required 5", acc_at_drop); end
    checks++; if (n_issue !== 6 || n_rsp !== 6) begin
      errors++; $display("FAIL b2b_counts got issue=%0d rsp=%0d required 6 6", n_issue, n_rsp); end
    for (int k = 0; k < 6 && k < n_issue; k++) begin
      exp_data = ((32'h100 + 32'(k)) << 8) | 32'(k * 16 + 1);
      checks++; if (issue_data[k] !== exp_data) begin
        errors++; $display("FAIL b2b_data%0d got %h required %h", k, issue_data[k], exp_data); end
    end
    for (int k = 1; k < 6 && k < n_issue; k++) begin
      checks++; if (issue_cyc[k] - issue_cyc[k-1] !== 6) begin
        errors++; $display("FAIL b2b_spacing%0d got %0d required 6", k, issue_cyc[k] - issue_cyc[k-1]); end
    end
  endtask

  task automatic test_reset_mid_read;
    int n_bad;
    push_a(1'b1, 15'h0AAA, 8'h00);
    a_cmd_valid = 1'b1; a_cmd_read = 1'b0; a_cmd_addr = 15'h0011; a_cmd_wdata = 8'h22;
    @(posedge clk); #1;
    a_cmd_addr = 15'h0033; a_cmd_wdata = 8'h44;
    @(posedge clk); #1;
    a_cmd_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (a_busy !== 1'b1 || a_tocnt !== 8'd1) begin
      errors++; $display("FAIL mid_pre got busy=%b tocnt=%0d required 1 1", a_busy, a_tocnt); end
    #2 a_rst_n = 1'b0;
    #1;
    checks++; if ({a_cmd_ready, a_busy, a_rsp_valid, a_rsp_read, a_rsp_timeout} !== 5'b10000) begin
      errors++; $display("FAIL mid_rst_flags got %b required 10000", {a_cmd_ready, a_busy, a_rsp_valid, a_rsp_read, a_rsp_timeout}); end
    checks++; if ({a_tlen, a_tdata, a_tmask, a_rsp_rdata, a_tocnt} !== '0) begin
      errors++; $display("FAIL mid_rst_words got len=%h data=%h mask=%h tocnt=%h required 0", a_tlen, a_tdata, a_tmask, a_tocnt); end
    repeat (2) @(posedge clk);
    #1 a_rst_n = 1'b1;
    n_bad = 0;
    repeat (40) begin @(posedge clk); #1; if (a_rsp_valid || a_tlen != 0 || a_busy) n_bad++; end
    checks++; if (n_bad !== 0) begin errors++; $display("FAIL mid_after got active_cycles=%0d required 0", n_bad); end
  endtask

  task automatic test_coincide;
    int early;
    push_a(1'b1, 15'h2222, 8'h00);
    @(posedge clk); #1;
    early = 0;
    repeat (16) begin @(posedge clk); #1; if (a_rsp_valid) early++; end
    a_spi_rv = 1'b1; a_spi_rd = 32'h0000005A;
    @(posedge clk); #1;
    a_spi_rv = 1'b0; a_spi_rd = '0;
    checks++; if (early !== 0) begin errors++; $display("FAIL co_early got %0d required 0", early); end
    checks++; if ({a_rsp_valid, a_rsp_read, a_rsp_timeout} !== 3'b110) begin
      errors++; $display("FAIL co_flags got %b required 110", {a_rsp_valid, a_rsp_read, a_rsp_timeout}); end
    checks++; if (a_rsp_rdata !== 8'h5A || a_tocnt !== 8'd0) begin
      errors++; $display("FAIL co_data got rdata=%h tocnt=%0d required 5a 0", a_rsp_rdata, a_tocnt); end
    for (int k = 0; k < 20 && a_busy; k++) begin @(posedge clk); #1; end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL co_idle got busy=%b required 0", a_busy); end
  endtask

  initial begin
    a_cmd_valid = 0; a_cmd_read = 0; a_cmd_addr = '0; a_cmd_wdata = '0; a_spi_rv = 0; a_spi_rd = '0;
    b_cmd_valid = 0; b_cmd_read = 0; b_cmd_addr = '0; b_cmd_wdata = '0; b_spi_rv = 0; b_spi_rd = '0;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    @(posedge clk); #1;
    test_write;
    test_read_data;
    test_timeout;
    test_back_to_back;
    test_reset_mid_read;
    test_coincide;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
